// File: rtl/wishbone_slave_mem_resp_if.sv
// Wishbone B4 slave-side bus bundle for the memory responder.
// The master modport drives requests; the slave modport answers them.
interface wishbone_slave_mem_resp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int WAIT_W     = 4
);
   logic                    cyc_i;
   logic                    stb_i;
   logic                    we_i;
   logic [ADDR_WIDTH-1:0]   adr_i;
   logic [DATA_WIDTH-1:0]   dat_i;
   logic [DATA_WIDTH/8-1:0] sel_i;
   logic [WAIT_W-1:0]       wait_i;
   logic [DATA_WIDTH-1:0]   dat_o;
   logic                    ack_o;
   logic                    err_o;
   logic                    stall_o;

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, wait_i,
      output dat_o, ack_o, err_o, stall_o
   );

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i, wait_i,
      input  dat_o, ack_o, err_o, stall_o
   );
endinterface

// File: rtl/wishbone_slave_mem_resp.sv
// Wishbone B4 slave memory responder: classic or pipelined, runtime wait states,
// byte-lane writes and an error termination for word indices beyond DEPTH.
module wishbone_slave_mem_resp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter int WAIT_W     = 4,
   parameter int PIPELINED  = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   wishbone_slave_mem_resp_if.slave  bus
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int LB = $clog2(SW);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                 state_q;
   logic [WAIT_W-1:0]      cnt_q;
   logic                   ack_q;
   logic                   err_q;
   logic [DATA_WIDTH-1:0]  dat_q;

   logic                   req_we_q;
   logic [ADDR_WIDTH-1:0]  req_idx_q;
   logic [DATA_WIDTH-1:0]  req_dat_q;
   logic [SW-1:0]          req_sel_q;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [ADDR_WIDTH-1:0]  adr_idx;
   logic                   can_accept;
   logic                   accept;
   logic                   wait_done;
   logic                   resp_now;
   logic                   r_we;
   logic [ADDR_WIDTH-1:0]  r_idx;
   logic [DATA_WIDTH-1:0]  r_dat;
   logic [SW-1:0]          r_sel;
   logic                   r_ok;
   logic [AW-1:0]          r_adr;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
      return {1'b0, idx} < (ADDR_WIDTH+1)'(DEPTH);
   endfunction

   assign adr_idx = bus.adr_i >> LB;

   // The transfer answered at this edge is either a zero-wait request being
   // accepted right now, or the latched request whose wait count just expired.
   always_comb begin
      can_accept = (state_q == S_IDLE) || ((PIPELINED != 0) && (state_q == S_RESP));
      accept     = bus.cyc_i && bus.stb_i && can_accept;
      wait_done  = (state_q == S_WAIT) && bus.cyc_i && (cnt_q == WAIT_W'(1));
      resp_now   = (accept && (bus.wait_i == '0)) || wait_done;
      r_we       = req_we_q;
      r_idx      = req_idx_q;
      r_dat      = req_dat_q;
      r_sel      = req_sel_q;
      if (accept) begin
         r_we  = bus.we_i;
         r_idx = adr_idx;
         r_dat = bus.dat_i;
         r_sel = bus.sel_i;
      end
      r_ok  = in_range(r_idx);
      r_adr = AW'(r_idx);
   end

   always_ff @(posedge clk_i) begin
      if (resp_now && r_we && r_ok) begin
         for (int b = 0; b < SW; b++) begin
            if (r_sel[b]) mem[r_adr][8*b +: 8] <= r_dat[8*b +: 8];
         end
      end
      if (accept) begin
         req_we_q  <= bus.we_i;
         req_idx_q <= adr_idx;
         req_dat_q <= bus.dat_i;
         req_sel_q <= bus.sel_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         ack_q <= resp_now && r_ok;
         err_q <= resp_now && !r_ok;
         if (resp_now && !r_we && r_ok) dat_q <= mem[r_adr];
         if (accept) begin
            cnt_q   <= bus.wait_i;
            state_q <= (bus.wait_i == '0) ? S_RESP : S_WAIT;
         end else if (wait_done) begin
            cnt_q   <= '0;
            state_q <= S_RESP;
         end else if ((state_q == S_WAIT) && bus.cyc_i) begin
            cnt_q <= cnt_q - WAIT_W'(1);
         end else begin
            // Covers end of response and any cycle where the master dropped cyc_i.
            cnt_q   <= '0;
            state_q <= S_IDLE;
         end
      end
   end

   assign bus.dat_o   = dat_q;
   assign bus.ack_o   = ack_q;
   assign bus.err_o   = err_q;
   assign bus.stall_o = (PIPELINED != 0) && (state_q == S_WAIT);
endmodule

// File: tb/tb_wishbone_slave_mem_resp.sv
// Bench for wishbone_slave_mem_resp: a classic and a pipelined instance share one
// master driver; pipe selects which instance sees cyc_i and whose outputs are observed.
module tb_wishbone_slave_mem_resp;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe;
   logic        cyc, stb, we;
   logic [15:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic [3:0]  wt;
   logic [31:0] dat_o;
   logic        ack, err, stall;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wishbone_slave_mem_resp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_W(4)) bc ();
   wishbone_slave_mem_resp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .WAIT_W(4)) bp ();

   wishbone_slave_mem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(256), .WAIT_W(4),
                             .PIPELINED(0)) u_classic (.clk_i(clk), .rst_ni(rst_n), .bus(bc));
   wishbone_slave_mem_resp #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(256), .WAIT_W(4),
                             .PIPELINED(1)) u_pipe (.clk_i(clk), .rst_ni(rst_n), .bus(bp));

   assign bc.cyc_i  = cyc & ~pipe;
   assign bc.stb_i  = stb;
   assign bc.we_i   = we;
   assign bc.adr_i  = adr;
   assign bc.dat_i  = dat;
   assign bc.sel_i  = sel;
   assign bc.wait_i = wt;
   assign bp.cyc_i  = cyc & pipe;
   assign bp.stb_i  = stb;
   assign bp.we_i   = we;
   assign bp.adr_i  = adr;
   assign bp.dat_i  = dat;
   assign bp.sel_i  = sel;
   assign bp.wait_i = wt;

   assign dat_o = pipe ? bp.dat_o   : bc.dat_o;
   assign ack   = pipe ? bp.ack_o   : bc.ack_o;
   assign err   = pipe ? bp.err_o   : bc.err_o;
   assign stall = pipe ? bp.stall_o : bc.stall_o;

   typedef struct {
      logic        pipe;
      logic        we;
      logic [15:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [3:0]  wt;
      logic        exp_err;
      logic [31:0] exp_dat;
      logic        chk_dat;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] model_mem [2][16];

   function automatic vec_t mk(input logic p, input logic w, input logic [15:0] a,
                               input logic [31:0] d, input logic [3:0] s, input logic [3:0] t,
                               input logic e, input logic [31:0] xd, input logic c);
      vec_t v;
      v.pipe = p; v.we = w; v.adr = a; v.dat = d; v.sel = s; v.wt = t;
      v.exp_err = e; v.exp_dat = xd; v.chk_dat = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One strobe cycle, then watch for the termination; latency is counted from the accept cycle.
   task automatic do_xfer(input vec_t v, input string tag);
      int          lat;
      int          stalls;
      logic        got_ack, got_err, both;
      logic [31:0] got_dat;
      lat = 0; stalls = 0; got_ack = 0; got_err = 0; both = 0; got_dat = '0;
      pipe = v.pipe;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = v.we; adr = v.adr; dat = v.dat; sel = v.sel; wt = v.wt;
      @(posedge clk); #1;
      stb = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ack && err) both = 1;
         if (ack || err) begin
            lat = k; got_ack = ack; got_err = err; got_dat = dat_o;
            break;
         end
         if (stall) stalls++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      cyc = 0;
      check({tag, " latency"}, 32'(lat), 32'(1 + int'(v.wt)));
      check({tag, " err_o"}, 32'(got_err), 32'(v.exp_err));
      check({tag, " ack_o"}, 32'(got_ack), 32'(!v.exp_err));
      check({tag, " stall cycles"}, 32'(stalls), v.pipe ? 32'(v.wt) : 32'd0);
      check({tag, " ack&err overlap"}, 32'(both), 32'd0);
      if (v.chk_dat) check({tag, " dat_o"}, got_dat, v.exp_dat);
   endtask

   task automatic check_quiet(input string tag, input int n);
      logic seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (ack || err) seen = 1;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [15:0] a;
      logic [3:0]  s;
      int          idx;
      logic        oor, w;

      rst_n = 0; pipe = 0; cyc = 0; stb = 0; we = 0; adr = '0; dat = '0; sel = '0; wt = '0;

      vecs.push_back(mk(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 4'd0, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 16'h0010, 32'h0,        4'hF, 4'd0, 0, 32'hDEADBEEF, 1));
      vecs.push_back(mk(0, 0, 16'h0010, 32'h0,        4'hF, 4'd3, 0, 32'hDEADBEEF, 1));
      vecs.push_back(mk(0, 1, 16'h0020, 32'h11223344, 4'hF, 4'd0, 0, 32'h0, 0));
      vecs.push_back(mk(0, 1, 16'h0020, 32'hAABBCCDD, 4'h5, 4'd1, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 16'h0022, 32'h0,        4'hF, 4'd2, 0, 32'h11BB33DD, 1));
      vecs.push_back(mk(0, 1, 16'h0020, 32'hFFFFFFFF, 4'h0, 4'd0, 0, 32'h0, 0));
      vecs.push_back(mk(0, 0, 16'h0020, 32'h0,        4'hF, 4'd0, 0, 32'h11BB33DD, 1));
      vecs.push_back(mk(0, 1, 16'h0000, 32'hCAFEF00D, 4'hF, 4'd0, 0, 32'h0, 0));
      vecs.push_back(mk(0, 1, 16'h0400, 32'h12345678, 4'hF, 4'd0, 1, 32'h0, 0));
      vecs.push_back(mk(0, 0, 16'h0000, 32'h0,        4'hF, 4'd0, 0, 32'hCAFEF00D, 1));
      vecs.push_back(mk(0, 0, 16'hFFFC, 32'h0,        4'hF, 4'd2, 1, 32'h0, 0));
      vecs.push_back(mk(1, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 4'd0, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 16'h0010, 32'h0,        4'hF, 4'd3, 0, 32'hDEADBEEF, 1));
      vecs.push_back(mk(1, 1, 16'h0020, 32'h11223344, 4'hF, 4'd2, 0, 32'h0, 0));
      vecs.push_back(mk(1, 1, 16'h0020, 32'hAABBCCDD, 4'h5, 4'd0, 0, 32'h0, 0));
      vecs.push_back(mk(1, 0, 16'h0020, 32'h0,        4'hF, 4'd1, 0, 32'h11BB33DD, 1));
      vecs.push_back(mk(1, 1, 16'h0400, 32'h12345678, 4'hF, 4'd3, 1, 32'h0, 0));
      vecs.push_back(mk(1, 0, 16'h0010, 32'h0,        4'hF, 4'd0, 0, 32'hDEADBEEF, 1));

      // Reset state of both instances.
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         pipe = m[0];
         #1;
         check($sformatf("reset ack m%0d", m), 32'(ack), 32'd0);
         check($sformatf("reset err m%0d", m), 32'(err), 32'd0);
         check($sformatf("reset stall m%0d", m), 32'(stall), 32'd0);
         check($sformatf("reset dat_o m%0d", m), dat_o, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1;

      for (int i = 0; i < vecs.size(); i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

      // Pipelined zero-wait burst: four reads accepted on consecutive cycles.
      for (int i = 0; i < 4; i++)
         do_xfer(mk(1, 1, 16'(16'h0040 + 4*i), 32'hA0A00000 + 32'(i), 4'hF, 4'd0, 0, 32'h0, 0),
                 $sformatf("burst fill%0d", i));
      pipe = 1;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; wt = 0; sel = 4'hF; adr = 16'h0040;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("burst stall c%0d", i), 32'(stall), 32'd0);
         if (i > 0) begin
            check($sformatf("burst ack c%0d", i), 32'(ack), 32'd1);
            check($sformatf("burst dat c%0d", i), dat_o, 32'hA0A00000 + 32'(i - 1));
         end
         @(posedge clk); #1;
         if (i < 3) adr = 16'(16'h0040 + 4*(i + 1));
         else stb = 0;
      end
      @(negedge clk);
      check("burst ack c4", 32'(ack), 32'd1);
      check("burst dat c4", dat_o, 32'hA0A00003);
      check("burst stall c4", 32'(stall), 32'd0);
      @(negedge clk);
      check("burst ack after", 32'(ack), 32'd0);
      @(posedge clk); #1;
      cyc = 0;

      // Abort: classic write with 5 wait states, cyc_i dropped two cycles into the wait.
      pipe = 0;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 1; adr = 16'h0010; dat = 32'h0BADF00D; sel = 4'hF; wt = 4'd5;
      @(posedge clk); #1;
      stb = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc = 0;
      check_quiet("abort no response", 10);
      do_xfer(mk(0, 0, 16'h0010, 32'h0, 4'hF, 4'd0, 0, 32'hDEADBEEF, 1), "after abort");

      // Reset pulse while the pipelined instance is waiting.
      pipe = 1;
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = 0; adr = 16'h0020; wt = 4'd5;
      @(posedge clk); #1;
      stb = 0;
      @(negedge clk);
      check("stall before reset", 32'(stall), 32'd1);
      #1 rst_n = 0;
      #1;
      check("mid-reset stall", 32'(stall), 32'd0);
      check("mid-reset ack", 32'(ack), 32'd0);
      check("mid-reset err", 32'(err), 32'd0);
      check("mid-reset dat_o", dat_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      check_quiet("no response after reset", 10);
      @(posedge clk); #1;
      cyc = 0;
      do_xfer(mk(1, 0, 16'h0020, 32'h0, 4'hF, 4'd0, 0, 32'h11BB33DD, 1), "after reset");

      // Randomized traffic against a word-array reference model, per instance.
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model_mem[m][i] = d;
            do_xfer(mk(m[0], 1, 16'(16'h0100 + 4*i), d, 4'hF, 4'($urandom_range(0, 4)), 0, 32'h0, 0),
                    $sformatf("rnd init m%0d w%0d", m, i));
         end
         for (int n = 0; n < 30; n++) begin
            oor = ($urandom_range(0, 5) == 0);
            idx = int'($urandom_range(0, 15));
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            if (oor) a = 16'($urandom_range(16'h0400, 16'hFFFF));
            else     a = 16'(16'h0100 + 4*idx + int'($urandom_range(0, 3)));
            do_xfer(mk(m[0], w, a, d, s, 4'($urandom_range(0, 4)), oor,
                       oor ? 32'h0 : model_mem[m][idx], !w && !oor),
                    $sformatf("rnd m%0d n%0d", m, n));
            if (w && !oor) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) model_mem[m][idx][8*b +: 8] = d[8*b +: 8];
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
